// File: rtl/req_client_pkg.sv
// Shared types and helpers for the requester-side client bank.
// Holds the default sizing and the one-hot to index helper.
package req_client_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 4;

    typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;

    // Callers pass a zero-extended vector; only legal one-hot
    // grants reach the output path, so ORing indices is enough.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_client_bank_if.sv
// Producer/arbiter/downstream bundle for req_client_bank.
// slave: the bank side; master: producers, arbiter and sink.
interface req_client_bank_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8
);
    logic [NUM_PORTS-1:0]         push_i;
    logic [NUM_PORTS*DATA_W-1:0]  push_data_i;
    logic [NUM_PORTS-1:0]         full_o;
    logic [NUM_PORTS-1:0]         req_o;
    logic [NUM_PORTS-1:0]         gnt_i;
    logic                         out_valid_o;
    logic [$clog2(NUM_PORTS)-1:0] out_port_o;
    logic [DATA_W-1:0]            out_data_o;
    logic                         gnt_err_o;

    modport slave (
        input  push_i, push_data_i, gnt_i,
        output full_o, req_o, out_valid_o,
        output out_port_o, out_data_o, gnt_err_o
    );

    modport master (
        output push_i, push_data_i, gnt_i,
        input  full_o, req_o, out_valid_o,
        input  out_port_o, out_data_o, gnt_err_o
    );
endinterface

// File: rtl/req_fifo.sv
// Single-port queue: push/pop, head data, count, full/empty.
// Ports: clk, reset_n, i_push, i_pop, i_data, o_head, o_cnt, o_full, o_empty.
module req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [DATA_W-1:0]            i_data,
    output logic [DATA_W-1:0]            o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_cnt;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_head  = r_mem[r_rptr];

    // A full queue still accepts a push when it pops in the same
    // cycle: the freed head slot is the one being written.
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PW'(1);
            if (w_rd) r_rptr <= r_rptr + PW'(1);
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end
endmodule

// File: rtl/req_client_bank.sv
// Per-port request queues in front of a round robin arbiter.
// Ports: clk, reset_n, bus (slave): push/full/req/gnt/out/err.
module req_client_bank
    import req_client_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    req_client_bank_if.slave    bus
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0]    w_head [NUM_PORTS];
    logic [CW-1:0]        w_cnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_pop;
    logic                 w_any;
    logic                 w_multi;
    logic                 w_unreq;
    logic                 w_legal;
    logic [PW-1:0]        w_idx;

    logic                 r_valid;
    logic [PW-1:0]        r_port;
    logic [DATA_W-1:0]    r_data;
    logic                 r_err;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_q
        req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .i_push  (bus.push_i[i]),
            .i_pop   (w_pop[i]),
            .i_data  (bus.push_data_i[i*DATA_W +: DATA_W]),
            .o_head  (w_head[i]),
            .o_cnt   (w_cnt[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
        assign w_req[i] = (w_cnt[i] != '0);
    end

    // x & (x-1) clears the lowest set bit: nonzero means >1 bit.
    assign w_any   = |bus.gnt_i;
    assign w_multi = |(bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1)));
    assign w_unreq = |(bus.gnt_i & ~w_req);
    assign w_legal = w_any & ~w_multi & ~w_unreq;

    assign w_pop = w_legal ? (bus.gnt_i & ~w_empty) : '0;
    assign w_idx = PW'(onehot_to_idx(32'(bus.gnt_i)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_port  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_legal;
            if (w_legal) begin
                r_port <= w_idx;
                r_data <= w_head[w_idx];
            end
            if (w_any & ~w_legal) r_err <= 1'b1;
        end
    end

    assign bus.req_o       = w_req;
    assign bus.full_o      = w_full;
    assign bus.out_valid_o = r_valid;
    assign bus.out_port_o  = r_port;
    assign bus.out_data_o  = r_data;
    assign bus.gnt_err_o   = r_err;
endmodule

// File: tb/tb_req_client_bank.sv
// Directed bench for req_client_bank with a small RR arbiter model.
// Drives inputs 1ns after the rising edge and samples there too.
module tb_req_client_bank;
    import req_client_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   rr_last;
    int   n;
    logic [31:0] got_port [8];
    logic [31:0] got_data [8];

    req_client_bank_if #(.NUM_PORTS(4), .DATA_W(8)) bus ();

    req_client_bank #(
        .NUM_PORTS (4),
        .DATA_W    (8),
        .DEPTH     (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.push_i      = '0;
        bus.push_data_i = '0;
        bus.gnt_i       = '0;
    endtask

    task automatic push1(input int p, input logic [7:0] d);
        bus.push_i               = '0;
        bus.push_i[p]            = 1'b1;
        bus.push_data_i[p*8 +: 8] = d;
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        #1;
        chk("rst_req",   32'(bus.req_o), 0);
        chk("rst_valid", 32'(bus.out_valid_o), 0);
        chk("rst_err",   32'(bus.gnt_err_o), 0);
        tick();
        reset_n = 1'b1;
    endtask

    // Round robin model: scan starting after the last winner.
    task automatic arb_drive();
        int idx;
        bus.gnt_i = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = (rr_last + i) % 4;
            if (bus.req_o[idx] && bus.gnt_i == '0) begin
                bus.gnt_i[idx] = 1'b1;
                rr_last = idx;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle_in();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        chk("idle_req",   32'(bus.req_o), 0);
        chk("idle_full",  32'(bus.full_o), 0);
        chk("idle_valid", 32'(bus.out_valid_o), 0);
        chk("idle_err",   32'(bus.gnt_err_o), 0);
        chk("idle_port",  32'(bus.out_port_o), 0);
        chk("idle_data",  32'(bus.out_data_o), 0);

        // single transfer on port 2
        push1(2, 8'hA5);
        tick();
        idle_in();
        chk("st_req", 32'(bus.req_o), 32'b0100);
        bus.gnt_i = 4'b0100;
        tick();
        bus.gnt_i = '0;
        chk("st_valid", 32'(bus.out_valid_o), 1);
        chk("st_port",  32'(bus.out_port_o), 2);
        chk("st_data",  32'(bus.out_data_o), 32'hA5);
        chk("st_req0",  32'(bus.req_o), 0);
        tick();
        chk("st_vdrop", 32'(bus.out_valid_o), 0);
        chk("st_hold",  32'(bus.out_data_o), 32'hA5);

        // round robin with arbiter model
        rr_last = 3;
        bus.push_i = 4'b1001;
        bus.push_data_i[0 +: 8]  = 8'h10;
        bus.push_data_i[24 +: 8] = 8'h30;
        tick();
        push1(0, 8'h11);
        arb_drive();
        tick();
        idle_in();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid_o && n < 8) begin
                got_port[n] = 32'(bus.out_port_o);
                got_data[n] = 32'(bus.out_data_o);
                n++;
            end
            arb_drive();
            tick();
        end
        idle_in();
        chk("rr_count", n, 3);
        chk("rr_p0", got_port[0], 0);
        chk("rr_d0", got_data[0], 32'h10);
        chk("rr_p1", got_port[1], 3);
        chk("rr_d1", got_data[1], 32'h30);
        chk("rr_p2", got_port[2], 0);
        chk("rr_d2", got_data[2], 32'h11);
        chk("rr_err", 32'(bus.gnt_err_o), 0);

        // full boundary on port 1
        for (int k = 1; k <= 4; k++) begin
            push1(1, 8'(k));
            tick();
        end
        idle_in();
        chk("fb_full", 32'(bus.full_o), 32'b0010);
        chk("fb_req",  32'(bus.req_o), 32'b0010);
        push1(1, 8'h05);
        tick();
        chk("fb_full5", 32'(bus.full_o), 32'b0010);
        push1(1, 8'h06);
        bus.gnt_i = 4'b0010;
        tick();
        bus.push_i = '0;
        chk("fb_full6", 32'(bus.full_o), 32'b0010);
        chk("fb_v1", 32'(bus.out_valid_o), 1);
        chk("fb_p1", 32'(bus.out_port_o), 1);
        chk("fb_d1", 32'(bus.out_data_o), 32'h01);
        tick();
        chk("fb_d2", 32'(bus.out_data_o), 32'h02);
        chk("fb_nf", 32'(bus.full_o), 0);
        tick();
        chk("fb_d3", 32'(bus.out_data_o), 32'h03);
        tick();
        chk("fb_d4", 32'(bus.out_data_o), 32'h04);
        tick();
        bus.gnt_i = '0;
        chk("fb_d6", 32'(bus.out_data_o), 32'h06);
        chk("fb_v6", 32'(bus.out_valid_o), 1);
        chk("fb_req0", 32'(bus.req_o), 0);

        // illegal multi-bit grant
        bus.push_i = 4'b0011;
        bus.push_data_i[0 +: 8] = 8'h40;
        bus.push_data_i[8 +: 8] = 8'h41;
        tick();
        idle_in();
        bus.gnt_i = 4'b0011;
        tick();
        bus.gnt_i = '0;
        chk("il_err",   32'(bus.gnt_err_o), 1);
        chk("il_valid", 32'(bus.out_valid_o), 0);
        chk("il_req",   32'(bus.req_o), 32'b0011);
        tick();
        tick();
        chk("il_sticky", 32'(bus.gnt_err_o), 1);
        chk("il_req2",   32'(bus.req_o), 32'b0011);

        // grant to a non-requesting port
        do_reset();
        tick();
        chk("ir_err0", 32'(bus.gnt_err_o), 0);
        chk("ir_req0", 32'(bus.req_o), 0);
        bus.gnt_i = 4'b1000;
        tick();
        bus.gnt_i = '0;
        chk("ir_err",   32'(bus.gnt_err_o), 1);
        chk("ir_valid", 32'(bus.out_valid_o), 0);

        // reset mid-stream with an output word in flight
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            push1(0, 8'(8'h50 + k));
            tick();
        end
        idle_in();
        chk("ms_req", 32'(bus.req_o), 32'b0001);
        bus.gnt_i = 4'b0001;
        tick();
        chk("ms_v",  32'(bus.out_valid_o), 1);
        chk("ms_d",  32'(bus.out_data_o), 32'h50);
        #2;
        reset_n = 1'b0;
        bus.gnt_i = '0;
        #1;
        chk("ms_rv",  32'(bus.out_valid_o), 0);
        chk("ms_rd",  32'(bus.out_data_o), 0);
        chk("ms_rp",  32'(bus.out_port_o), 0);
        chk("ms_rq",  32'(bus.req_o), 0);
        chk("ms_rf",  32'(bus.full_o), 0);
        chk("ms_re",  32'(bus.gnt_err_o), 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ms_post_req", 32'(bus.req_o), 0);
            chk("ms_post_v",   32'(bus.out_valid_o), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/req_client_bank.md
Name: req_client_bank

Overview:
- Requester-side front end for the 4-way round robin arbiter: per-port transaction queues that drive `req_o` and consume the arbiter's one-hot `gnt_i`.
- Each port buffers pushed data words and holds its request while its queue is non-empty.
- On grant, the port pops its head entry. The granted word appears on a single registered output channel one cycle later, tagged with its source port.
- Sits between N producer clients and the arbiter / shared downstream resource.

Parameters:
- NUM_PORTS, 4, number of requesting ports (matches arbiter width).
- DATA_W, 8, payload width per entry.
- DEPTH, 4, entries per port queue; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push_i  input  NUM_PORTS  per-port push strobe.
- push_data_i  input  NUM_PORTS*DATA_W  port i data at bits [i*DATA_W +: DATA_W].
- full_o  output  NUM_PORTS  port queue holds DEPTH entries.
- req_o  output  NUM_PORTS  request to arbiter; port queue non-empty.
- gnt_i  input  NUM_PORTS  grant from arbiter; expected one-hot or zero.
- out_valid_o  output  1  registered: a granted word is presented this cycle.
- out_port_o  output  $clog2(NUM_PORTS)  index of the port that was granted.
- out_data_o  output  DATA_W  granted payload.
- gnt_err_o  output  1  sticky: illegal grant seen; cleared only by reset.

Behaviour:
- Reset (async assert, sync-safe deassert by the environment) clears:
  - all queue pointers and occupancy counts, giving `req_o`=0 and `full_o`=0;
  - `out_valid_o`=0, `out_port_o`=0, `out_data_o`=0, `gnt_err_o`=0.
- Reset mid-operation discards all queued entries. An in-flight output word is lost.
- Per port i: occupancy `cnt[i]` has width $clog2(DEPTH+1). Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `req_o[i]` = (`cnt[i]` != 0) and `full_o[i]` = (`cnt[i]` == DEPTH). Both derive from registered state only; there is no combinational path from `gnt_i` or `push_i`.
- Legal grant: `gnt_i` is exactly one-hot, and its bit k has `req_o[k]`=1.
  - pop_k fires.
  - Next cycle: `out_valid_o`=1, `out_port_o`=k, `out_data_o` = the head entry of port k as it was in the grant cycle.
  - Latency from grant to output: 1 cycle.
- Cycles with no legal grant: `out_valid_o`=0 next cycle. `out_port_o` and `out_data_o` hold their last values.
- Illegal grant: more than one bit set, or any granted bit whose `req_o` is 0.
  - No pop occurs on any port.
  - `gnt_err_o` is set next cycle and stays set.
  - `out_valid_o`=0.
- Push on port i is accepted if `full_o[i]`=0, or if port i pops in the same cycle.
  - Full queue with simultaneous push and pop: count stays DEPTH, and the data order is preserved.
  - Push on a full queue without a pop is dropped silently; the producer must honour `full_o`.
- Push and pop on the same port with `cnt`=1: the head is popped, the new word becomes the head, `cnt` stays 1, and `req_o` stays high.
- Push to an empty queue: `req_o` rises the next cycle. There is no same-cycle bypass.
- Ports are independent. Any combination of pushes may coincide with one pop.
- FIFO order is strict per port. Inter-port ordering is defined solely by the arbiter.

Decomposition:
- Shared package `req_client_pkg`:
  - localparams for default NUM_PORTS, DATA_W, DEPTH;
  - typedef `port_idx_t` (logic [$clog2(NUM_PORTS)-1:0]);
  - function `onehot_to_idx`.
- One sub-module, `req_fifo`, instantiated NUM_PORTS times via generate. It is a single-port queue with push, pop, data in, head data, count, and full/empty outputs.
- Top level holds:
  - the grant legality check (onehot and masked-by-req check);
  - the pop decode;
  - the head mux;
  - the output register;
  - the error flag.

Test Plan:
- Reset and idle: after `reset_n` rises, with no pushes and `gnt_i`=0 -> `req_o`=0000, `full_o`=0000, `out_valid_o`=0, `gnt_err_o`=0.
- Single transfer: push 0xA5 on port 2 -> `req_o`=0100 next cycle. Grant `gnt_i`=0100 for one cycle -> next cycle `out_valid_o`=1, `out_port_o`=2, `out_data_o`=0xA5, then `req_o`=0000.
- Round robin with the arbiter connected: push 0x10,0x11 on port 0 and 0x30 on port 3 -> output sequence (port,data) = (0,0x10),(3,0x30),(0,0x11), each with `out_valid_o`=1.
- Full boundary: push 4 words 0x01..0x04 on port 1 -> `full_o[1]`=1. A 5th push 0x05 with no grant is dropped. Then push 0x06 with `gnt_i`=0010 in the same cycle -> `cnt` stays 4, and drained data reads 0x01,0x02,0x03,0x04,0x06.
- Illegal grants: `gnt_i`=0011 with ports 0 and 1 requesting -> no pop, `gnt_err_o`=1 next cycle and sticky. After reset, `gnt_i`=1000 with `req_o[3]`=0 -> `gnt_err_o`=1, `out_valid_o`=0.
- Reset mid-stream: 3 entries queued on port 0 and a grant in flight, assert `reset_n`=0 asynchronously -> all outputs 0 immediately. After release, `req_o`=0000 and no stale data emerges.
